// File: rtl/y86_pkg.sv
// Y86-64 icode/stat encodings and run-state codes shared by the hazard controller and its bench.
// Pure definitions: no latency, no flow control.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_BUB = 3'd0;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_ERROR  = 2'd2;

    typedef enum logic [1:0] {
        RS_RUN    = ST_RUN,
        RS_HALTED = ST_HALTED,
        RS_ERROR  = ST_ERROR
    } run_state_e;

    // HLT counts as an exception here: it must stop younger stages from committing.
    function automatic logic stat_exc(input logic [2:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per enabled cycle, sticks at all-ones; value visible one cycle after enable.
// No backpressure; async active-low clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard controls (combinational, same cycle), run-state FSM and perf counters (registered).
// Outside RUN the pipeline is frozen; the controller itself never backpressures.
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic             e_cnd,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             cpu_halted,
    output logic             cpu_error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [1:0] state;
    logic       run;
    logic       load_use;
    logic       ret_hz;
    logic       mispred;
    logic       m_exc;
    logic       w_exc;
    logic       retire;

    assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE)
                      && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_hz   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_cnd;
    assign m_exc    = stat_exc(m_stat);
    assign w_exc    = stat_exc(W_stat);
    assign retire   = (W_stat == S_AOK) && (W_icode != I_NOP);
    assign run      = (state == ST_RUN);

    // A mispredict squashes the load-use victim in D, so it drops the D stall.
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
        if (run) begin
            F_stall  = load_use || ret_hz;
            D_stall  = load_use && !mispred;
            D_bubble = mispred || (ret_hz && !load_use);
            E_bubble = mispred || load_use;
            M_bubble = m_exc || w_exc;
            W_stall  = w_exc;
            set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (run) begin
            if (W_stat == S_HLT) begin
                state <= ST_HALTED;
            end else if ((W_stat == S_ADR) || (W_stat == S_INS)) begin
                state <= ST_ERROR;
            end
        end
    end

    assign cpu_halted = (state == ST_HALTED);
    assign cpu_error  = (state == ST_ERROR);

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst_n(rst_n), .en(run), .cnt(cycle_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk(clk), .rst_n(rst_n), .en(run && retire), .cnt(retire_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .en(run && load_use), .cnt(stall_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .en(run && mispred), .cnt(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (CNT_W=4 so saturation is reachable quickly).
// Expected controls are queued at drive time and popped when outputs settle.
module tb_pipe_hazard_ctrl;
    import y86_pkg::*;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
        logic set_cc;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB;
    logic e_cnd;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic cpu_halted, cpu_error;
    logic [CW-1:0] cycle_cnt, retire_cnt, stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    ctl_t exp_q[$];

    logic [1:0]    m_st;
    logic [CW-1:0] m_cyc, m_ret, m_stl, m_fl;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .e_cnd(e_cnd), .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .cpu_halted(cpu_halted), .cpu_error(cpu_error),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic logic m_lu();
        return ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF)
               && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    endfunction

    function automatic logic m_mp();
        return (E_icode == 4'h7) && !e_cnd;
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t c;
        logic lu, rh, mp, mx, wx;
        lu = m_lu();
        mp = m_mp();
        rh = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mx = is_exc(m_stat);
        wx = is_exc(W_stat);
        if (m_st != ST_RUN) begin
            c = '{f_stall: 1'b1, d_stall: 1'b1, d_bubble: 1'b0, e_bubble: 1'b1,
                  m_bubble: 1'b1, w_stall: 1'b1, set_cc: 1'b0};
        end else begin
            c.f_stall  = lu | rh;
            c.d_stall  = lu & ~mp;
            c.d_bubble = mp | (rh & ~lu);
            c.e_bubble = mp | lu;
            c.m_bubble = mx | wx;
            c.w_stall  = wx;
            c.set_cc   = (E_icode == 4'h6) & ~mx & ~wx;
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    task automatic model_reset();
        m_st = ST_RUN;
        m_cyc = '0; m_ret = '0; m_stl = '0; m_fl = '0;
    endtask

    task automatic model_tick();
        if (m_st == ST_RUN) begin
            m_cyc = sat_inc(m_cyc);
            if ((W_stat == 3'd1) && (W_icode != 4'h1)) m_ret = sat_inc(m_ret);
            if (m_lu()) m_stl = sat_inc(m_stl);
            if (m_mp()) m_fl = sat_inc(m_fl);
            if (W_stat == 3'd2) m_st = ST_HALTED;
            else if ((W_stat == 3'd3) || (W_stat == 3'd4)) m_st = ST_ERROR;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ":halted"}, 32'(cpu_halted), 32'(m_st == ST_HALTED));
        check({tag, ":error"},  32'(cpu_error),  32'(m_st == ST_ERROR));
        check({tag, ":cycle"},  32'(cycle_cnt),  32'(m_cyc));
        check({tag, ":retire"}, 32'(retire_cnt), 32'(m_ret));
        check({tag, ":stall"},  32'(stall_cnt),  32'(m_stl));
        check({tag, ":flush"},  32'(flush_cnt),  32'(m_fl));
    endtask

    task automatic idle();
        D_icode = I_NOP; E_icode = I_NOP; M_icode = I_NOP; W_icode = I_NOP;
        e_cnd = 1'b1; E_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
        m_stat = S_AOK; W_stat = S_BUB;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        ctl_t o, e;
        exp_q.push_back(model_ctl());
        #1;
        o = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
        e = exp_q.pop_front();
        check({tag, ":ctl"}, 32'(o), 32'(e));
        check_regs(tag);
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs(tag);
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        idle(); step("idle");
        idle(); E_icode = I_MRMOVQ; E_dstM = 4'h0; d_srcA = 4'h0; step("lu_mrmov_srcA");
        idle(); E_icode = I_POPQ; E_dstM = 4'h4; d_srcB = 4'h4; step("lu_popq_srcB");
        idle(); E_icode = I_MRMOVQ; E_dstM = RNONE; d_srcA = RNONE; step("lu_rnone");
        idle(); E_icode = I_MRMOVQ; E_dstM = 4'h2; d_srcA = 4'h3; step("lu_nomatch");
        idle(); E_icode = I_JXX; e_cnd = 1'b0; step("mispred");
        idle(); E_icode = I_JXX; e_cnd = 1'b1; step("jxx_taken");
        idle(); D_icode = I_RET; E_icode = I_JXX; e_cnd = 1'b0; step("ret_mispred");
        idle(); D_icode = I_RET; step("ret_d");
        idle(); E_icode = I_RET; step("ret_e");
        idle(); M_icode = I_RET; step("ret_m");
        idle(); step("ret_clear");
        idle(); D_icode = I_RET; E_icode = I_MRMOVQ; E_dstM = 4'h1; d_srcB = 4'h1; step("ret_lu");
        idle(); E_icode = I_OPQ; step("opq_cc");
        idle(); E_icode = I_OPQ; W_stat = S_AOK; W_icode = I_NOP; step("aok_nop");

        for (int i = 0; i < 16; i++) begin
            idle(); W_stat = S_AOK; W_icode = I_OPQ; step("retire");
            if (i % 4 == 0) begin
                idle(); W_stat = S_BUB; W_icode = I_NOP; step("bubble");
            end
        end
        idle(); step("retire_sat");

        idle(); E_icode = I_OPQ; m_stat = S_ADR; step("m_adr");
        idle(); E_icode = I_OPQ; W_stat = S_ADR; W_icode = I_MRMOVQ; step("w_adr");
        idle(); E_icode = I_JXX; e_cnd = 1'b0; D_icode = I_RET; step("err_frozen");
        idle(); E_icode = I_OPQ; W_stat = S_AOK; W_icode = I_OPQ; step("err_hold");

        idle(); pulse_reset("rst_from_err");
        idle(); step("post_rst");
        idle(); W_stat = S_INS; step("w_ins");
        idle(); step("ins_err");
        idle(); pulse_reset("rst_from_ins");

        idle(); W_stat = S_HLT; m_stat = S_ADR; step("w_hlt_m_adr");
        idle(); E_icode = I_MRMOVQ; E_dstM = 4'h0; d_srcA = 4'h0; step("halted_frozen");
        idle(); W_stat = S_ADR; step("halted_absorb");
        idle(); pulse_reset("rst_from_hlt");
        idle(); E_icode = I_OPQ; step("final_run");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
